// File: rtl/fifo_uart_drain_pkg.sv
// Shared types and constants for the sample-FIFO UART drain: FSM encoding, frame header, UART framing.
package fifo_uart_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_POP     = 3'd2,
        ST_TX_SYNC = 3'd3,
        ST_TX_HI   = 3'd4,
        ST_TX_LO   = 3'd5,
        ST_GUARD   = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         UART_BITS     = 10;
    localparam logic [3:0] UART_LAST_BIT = 4'(UART_BITS - 1);

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/fifo_uart_drain_uart_tx.sv
// 8N1 serial transmitter: start accepted when ready, txd registered (1 clk after start), no backpressure beyond ready.
// ready is also high in the last stop-bit cycle so consecutive bytes go out back-to-back.
module uart_tx_8n1
    import fifo_uart_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       ready
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    shreg_q, shreg_d;
    logic          active_q, active_d;
    logic          txd_q, txd_d;
    logic          bit_end, last_cycle;

    assign bit_end    = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign last_cycle = active_q & bit_end & (bit_q == UART_LAST_BIT);
    assign ready      = ~active_q | last_cycle;
    assign txd        = txd_q;

    always_comb begin
        baud_d   = baud_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        active_d = active_q;
        txd_d    = txd_q;
        if (start && ready) begin
            txd_d    = 1'b0;
            shreg_d  = {1'b1, data};
            bit_d    = '0;
            baud_d   = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (bit_end) begin
                baud_d = '0;
                if (bit_q == UART_LAST_BIT) begin
                    active_d = 1'b0;
                end else begin
                    // shreg carries the stop bit in its top so bit 9 falls out naturally
                    txd_d   = shreg_q[0];
                    shreg_d = {1'b1, shreg_q[8:1]};
                    bit_d   = bit_q + 4'd1;
                end
            end else begin
                baud_d = baud_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '1;
            active_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            active_q <= active_d;
            txd_q    <= txd_d;
        end
    end

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops one FIFO word at a time and ships it as a 3-byte UART frame (SYNC, hi, lo); start bit 4 clks after avail.
// No backpressure: the FIFO is only popped from IDLE, so words arriving mid-frame wait in the FIFO.
module fifo_uart_drain
    import fifo_uart_drain_pkg::*;
#(
    parameter int         CLK_HZ    = 50_000_000,
    parameter int         BAUD      = 115200,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         SETTLE    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_data,
    output logic        fifo_rd_inc,
    output logic        uart_txd,
    output logic        busy,
    output logic [15:0] words_sent
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int GW           = $clog2(SETTLE + 1);

    state_t        state_q, state_d;
    logic [2:0]    sync_q, sync_d;
    logic [15:0]   word_q, word_d;
    logic [15:0]   words_q, words_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          rd_inc_q, rd_inc_d;
    logic          busy_q, busy_d;
    logic          launched_q, launched_d;
    logic          avail, guard_done;
    logic          tx_start, tx_ready;
    logic [7:0]    tx_data;

    // sync_q[1] is the synchronized flag; sync_q[2] its previous value for the 2-cycle qualifier
    assign sync_d     = {sync_q[1:0], fifo_empty};
    assign avail      = ~sync_q[1] & ~sync_q[2];
    assign guard_done = (guard_q == GW'(SETTLE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (enable && avail)          state_d = ST_LATCH;
            ST_LATCH:                                 state_d = ST_POP;
            ST_POP:                                   state_d = ST_TX_SYNC;
            ST_TX_SYNC: if (launched_q && tx_ready)   state_d = ST_TX_HI;
            ST_TX_HI:   if (launched_q && tx_ready)   state_d = ST_TX_LO;
            ST_TX_LO:   if (launched_q && tx_ready)   state_d = ST_GUARD;
            ST_GUARD:   if (guard_done)               state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    // launched_q marks that the byte named by the current state is already on the wire
    always_comb begin
        tx_start   = 1'b0;
        tx_data    = SYNC_BYTE;
        launched_d = launched_q;
        word_d     = word_q;
        words_d    = words_q;
        guard_d    = '0;
        rd_inc_d   = (state_q == ST_LATCH);
        busy_d     = (state_d != ST_IDLE);
        unique case (state_q)
            ST_LATCH: word_d = fifo_data;
            ST_POP:   launched_d = 1'b0;
            ST_TX_SYNC: begin
                tx_start   = tx_ready;
                tx_data    = launched_q ? word_q[15:8] : SYNC_BYTE;
                launched_d = launched_q | tx_ready;
            end
            ST_TX_HI: begin
                tx_start = tx_ready;
                tx_data  = word_q[7:0];
            end
            ST_TX_LO: begin
                if (tx_ready) begin
                    words_d    = words_q + 16'd1;
                    launched_d = 1'b0;
                end
            end
            ST_GUARD: guard_d = guard_q + GW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= 3'b111;
            word_q     <= '0;
            words_q    <= '0;
            guard_q    <= '0;
            rd_inc_q   <= 1'b0;
            busy_q     <= 1'b0;
            launched_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            word_q     <= word_d;
            words_q    <= words_d;
            guard_q    <= guard_d;
            rd_inc_q   <= rd_inc_d;
            busy_q     <= busy_d;
            launched_q <= launched_d;
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .start(tx_start),
        .data (tx_data),
        .txd  (uart_txd),
        .ready(tx_ready)
    );

    assign fifo_rd_inc = rd_inc_q;
    assign busy        = busy_q;
    assign words_sent  = words_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Randomized scoreboard bench: FIFO model pops on negedge rd_inc, a UART receiver checks bytes against expected frames.
module tb_fifo_uart_drain;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        fifo_rd_inc;
    logic        uart_txd;
    logic        busy;
    logic [15:0] words_sent;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_uart_drain #(
        .CLK_HZ   (1000),
        .BAUD     (100),
        .SYNC_BYTE(8'hA5),
        .SETTLE   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_inc(fifo_rd_inc),
        .uart_txd   (uart_txd),
        .busy       (busy),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: initial block writes, pop process reads
    logic [15:0] mem [0:255];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic        glitch = 1'b0;
    logic [7:0]  exp_q[$];

    assign fifo_empty = glitch ? 1'b0 : (wr_cnt == rd_cnt);
    assign fifo_data  = mem[rd_cnt[7:0]];

    always @(negedge fifo_rd_inc) begin
        if (wr_cnt == rd_cnt) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_on_empty: rd_inc fell with model FIFO empty at %0t", $time);
        end else begin
            rd_cnt++;
        end
    end

    task automatic push_word(input logic [15:0] w);
        mem[wr_cnt[7:0]] = w;
        wr_cnt++;
        exp_q.push_back(8'hA5);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    // Pop-strobe monitor: counts pulses, checks each is exactly one clk wide
    int pulse_cnt = 0;
    int hi_len    = 0;
    always @(negedge clk) begin
        if (fifo_rd_inc === 1'b1) begin
            if (hi_len == 0) pulse_cnt++;
            hi_len++;
        end else if (hi_len != 0) begin
            chk("rd_inc_width", hi_len, 1);
            hi_len = 0;
        end
    end

    // UART receiver, 10 clks/bit, samples mid-bit
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_act = 1'b0;
            rx_cnt = 0;
        end else if (!rx_act) begin
            if (uart_txd === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 5) begin
                chk("rx_start_bit", uart_txd, 1'b0);
            end else if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5) begin
                rx_byte = {uart_txd, rx_byte[7:1]};
            end else if (rx_cnt == 95) begin
                chk("rx_stop_bit", uart_txd, 1'b1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got byte %0h, expected none at %0t", rx_byte, $time);
                end else begin
                    chk("rx_byte", rx_byte, exp_q.pop_front());
                end
                rx_act = 1'b0;
            end
        end
    end

    task automatic wait_drained(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && busy === 1'b0 && wr_cnt == rd_cnt) done = 1'b1;
        end
        chk(name, done, 1'b1);
    endtask

    task automatic wait_pulse(input string name, input int budget);
        int  start = pulse_cnt;
        bit  seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (pulse_cnt != start) seen = 1'b1;
        end
        chk(name, seen, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_txd"},        uart_txd,    1'b1);
        chk({tag, "_rd_inc"},     fifo_rd_inc, 1'b0);
        chk({tag, "_busy"},       busy,        1'b0);
        chk({tag, "_words_sent"}, words_sent,  16'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int          p0;
        int          ws_exp;
        bit          all_high;
        bit          never_busy;
        logic [15:0] w;

        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        ws_exp = 0;

        // single word
        push_word(16'h1234);
        enable = 1'b1;
        p0 = pulse_cnt;
        wait_drained("single_drain", 600);
        ws_exp += 1;
        chk("single_words_sent", words_sent, 16'(ws_exp));
        chk("single_pulses", pulse_cnt - p0, 1);
        chk("single_model_empty", fifo_empty, 1'b1);

        // empty FIFO with a one-clk glitch on the empty flag
        p0         = pulse_cnt;
        all_high   = 1'b1;
        never_busy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            glitch = (i == 500);
            if (uart_txd !== 1'b1) all_high = 1'b0;
            if (busy !== 1'b0) never_busy = 1'b0;
        end
        glitch = 1'b0;
        chk("idle_txd_high", all_high, 1'b1);
        chk("idle_never_busy", never_busy, 1'b1);
        chk("idle_no_pops", pulse_cnt - p0, 0);

        // preloaded burst
        p0 = pulse_cnt;
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        wait_drained("burst_drain", 8 * 320 + 100);
        ws_exp += 8;
        chk("burst_words_sent", words_sent, 16'(ws_exp));
        chk("burst_pulses", pulse_cnt - p0, 8);
        repeat (20) @(negedge clk);
        chk("burst_idle_busy", busy, 1'b0);

        // enable drops during the hi byte of the first of three words
        p0 = pulse_cnt;
        for (int i = 0; i < 3; i++) push_word(16'($urandom));
        wait_pulse("en_first_pop", 100);
        repeat (150) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clk);
        chk("en_frame_done", busy, 1'b0);
        repeat (500) @(negedge clk);
        chk("en_hold_pulses", pulse_cnt - p0, 1);
        chk("en_hold_pending", exp_q.size(), 6);
        chk("en_hold_words_sent", words_sent, 16'(ws_exp + 1));
        enable = 1'b1;
        wait_drained("en_resume_drain", 2 * 320 + 100);
        ws_exp += 3;
        chk("en_words_sent", words_sent, 16'(ws_exp));
        chk("en_pulses", pulse_cnt - p0, 3);

        // reset during the lo byte truncates the frame; next word comes out clean
        w = 16'($urandom);
        push_word(w);
        wait_pulse("rst_first_pop", 100);
        repeat (250) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        ws_exp = 0;
        repeat (3) @(negedge clk);
        push_word(16'hBEEF);
        rst_n = 1'b1;
        p0 = pulse_cnt;
        wait_drained("rst_beef_drain", 600);
        ws_exp += 1;
        chk("rst_beef_words_sent", words_sent, 16'(ws_exp));
        chk("rst_beef_pulses", pulse_cnt - p0, 1);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
